// File: rtl/writeback_scoreboard_if.sv
// Bundle of the MEM-retire, register-file write-back and decode-scoreboard signals
// exchanged between writeback_scoreboard and its neighbours.
interface writeback_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
);
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_to_reg;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] alu_data_out;
  logic [DATA_W-1:0] mem_data_out;

  logic              reg_write;
  logic [4:0]        rd;
  logic [DATA_W-1:0] reg_wr_data;

  logic              id_set_valid;
  logic [4:0]        id_set_addr;
  logic              id_chk_use1;
  logic [4:0]        id_chk_addr1;
  logic              id_chk_use2;
  logic [4:0]        id_chk_addr2;

  logic              stall;
  logic [NREG-1:0]   busy_flags;
  logic [31:0]       retired_count;
  logic              sb_underflow;

  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_rd, alu_data_out, mem_data_out,
    input  id_set_valid, id_set_addr, id_chk_use1, id_chk_addr1, id_chk_use2, id_chk_addr2,
    output reg_write, rd, reg_wr_data, stall, busy_flags, retired_count, sb_underflow
  );

  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_rd, alu_data_out, mem_data_out,
    output id_set_valid, id_set_addr, id_chk_use1, id_chk_addr1, id_chk_use2, id_chk_addr2,
    input  reg_write, rd, reg_wr_data, stall, busy_flags, retired_count, sb_underflow
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// Write-back stage: registers MEM results into the register-file write port and keeps
// per-register pending-write counters that produce the decode RAW stall.
module writeback_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  writeback_scoreboard_if.slave bus
);

  logic              reg_write_q, reg_write_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [31:0]       retired_q, retired_d;
  logic              underflow_q, underflow_d;

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic              stall;
  logic              set_en;

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wr_data_d   = wr_data_q;
    if (bus.mem_valid) begin
      reg_write_d = bus.mem_reg_write && (bus.mem_rd != 5'd0);
      rd_d        = bus.mem_rd;
      wr_data_d   = bus.mem_to_reg ? bus.mem_data_out : bus.alu_data_out;
    end
  end

  // Entry 0 stays out of the busy vector so source r0 never stalls.
  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    stall = (bus.id_chk_use1 && busy[bus.id_chk_addr1])
          | (bus.id_chk_use2 && busy[bus.id_chk_addr2])
          | (bus.id_set_valid && (cnt_q[bus.id_set_addr] == '1));
    set_en = bus.id_set_valid && !stall && (bus.id_set_addr != 5'd0);
  end

  always_comb begin
    set_vec     = '0;
    clr_vec     = '0;
    retired_d   = retired_q;
    underflow_d = underflow_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      set_vec[i] = set_en && (bus.id_set_addr == 5'(i));
      clr_vec[i] = reg_write_q && (rd_q == 5'(i));
      cnt_d[i]   = cnt_q[i];
      // A coincident set and clear cancel; a clear of an empty entry floors at zero.
      if (set_vec[i] && !clr_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (clr_vec[i] && !set_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    if (reg_write_q) begin
      retired_d = retired_q + 32'd1;
      if (cnt_q[rd_q] == '0) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wr_data_q   <= '0;
      retired_q   <= '0;
      underflow_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wr_data_q   <= wr_data_d;
      retired_q   <= retired_d;
      underflow_q <= underflow_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.reg_write     = reg_write_q;
  assign bus.rd            = rd_q;
  assign bus.reg_wr_data   = wr_data_q;
  assign bus.stall         = stall;
  assign bus.busy_flags    = busy;
  assign bus.retired_count = retired_q;
  assign bus.sb_underflow  = underflow_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Randomised and directed bench for writeback_scoreboard against a counting-array model.
module tb_writeback_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  writeback_scoreboard_if #(.DATA_W(32), .NREG(32)) bus ();

  writeback_scoreboard #(.DATA_W(32), .NREG(32), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain integer counters and the last write-back transaction.
  int unsigned m_cnt [32];
  bit          m_rw;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  bit [31:0]   m_ret;
  bit          m_uf;
  logic        last_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_rw   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_ret  = '0;
    m_uf   = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_reg_write"}, 64'(bus.reg_write), 64'(m_rw));
    check({pfx, "_rd"}, 64'(bus.rd), 64'(m_rd));
    check({pfx, "_wr_data"}, 64'(bus.reg_wr_data), 64'(m_data));
    check({pfx, "_busy"}, 64'(bus.busy_flags), 64'(model_busy()));
    check({pfx, "_retired"}, 64'(bus.retired_count), 64'(m_ret));
    check({pfx, "_underflow"}, 64'(bus.sb_underflow), 64'(m_uf));
  endtask

  task automatic drive(input logic mv, input logic mrw, input logic m2r, input logic [4:0] mrd,
                       input logic [31:0] alu, input logic [31:0] md,
                       input logic sv, input logic [4:0] sa,
                       input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2);
    bus.mem_valid     = mv;
    bus.mem_reg_write = mrw;
    bus.mem_to_reg    = m2r;
    bus.mem_rd        = mrd;
    bus.alu_data_out  = alu;
    bus.mem_data_out  = md;
    bus.id_set_valid  = sv;
    bus.id_set_addr   = sa;
    bus.id_chk_use1   = u1;
    bus.id_chk_addr1  = a1;
    bus.id_chk_use2   = u2;
    bus.id_chk_addr2  = a2;
  endtask

  // One clock: drive, check the combinational stall, advance the model, check registered outputs.
  task automatic step(input logic mv, input logic mrw, input logic m2r, input logic [4:0] mrd,
                      input logic [31:0] alu, input logic [31:0] md,
                      input logic sv, input logic [4:0] sa,
                      input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2);
    bit exp_stall;
    bit do_set;
    bit do_clr;
    drive(mv, mrw, m2r, mrd, alu, md, sv, sa, u1, a1, u2, a2);
    #1;
    exp_stall = (u1 && a1 != 0 && m_cnt[a1] > 0) || (u2 && a2 != 0 && m_cnt[a2] > 0)
             || (sv && m_cnt[sa] == 3);
    check("stall", 64'(bus.stall), 64'(exp_stall));
    last_stall = bus.stall;
    do_set = sv && !exp_stall && sa != 0;
    do_clr = m_rw;
    if (do_clr) begin
      m_ret = m_ret + 1;
      if (m_cnt[m_rd] == 0) m_uf = 1'b1;
    end
    if (!(do_set && do_clr && sa == m_rd)) begin
      if (do_set) m_cnt[sa] = m_cnt[sa] + 1;
      if (do_clr && m_cnt[m_rd] > 0) m_cnt[m_rd] = m_cnt[m_rd] - 1;
    end
    if (mv) begin
      m_rw   = mrw && (mrd != 0);
      m_rd   = mrd;
      m_data = m2r ? md : alu;
    end else begin
      m_rw = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_reg(input logic [4:0] a);
    step(0, 0, 0, 0, 0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic use_reg(input logic [4:0] a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a, 0, 0);
  endtask

  task automatic retire(input logic mrw, input logic m2r, input logic [4:0] r,
                        input logic [31:0] alu, input logic [31:0] md);
    step(1, mrw, m2r, r, alu, md, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      3: return 5'd9;
      4: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    check("reset_stall", 64'(bus.stall), 64'd0);
    reset = 1'b1;

    // RAW hazard on r5 resolves one edge after the write-back pulse.
    set_reg(5);
    use_reg(5);
    check("t2_stall_busy", 64'(last_stall), 64'd1);
    retire(1, 0, 5, 32'h1234, 32'h0);
    check("t2_reg_write", 64'(bus.reg_write), 64'd1);
    check("t2_rd", 64'(bus.rd), 64'd5);
    check("t2_data", 64'(bus.reg_wr_data), 64'h1234);
    use_reg(5);
    check("t2_stall_retiring", 64'(last_stall), 64'd1);
    check("t2_busy5_clear", 64'(bus.busy_flags[5]), 64'd0);
    use_reg(5);
    check("t2_stall_gone", 64'(last_stall), 64'd0);

    retire(0, 1, 3, 32'h1, 32'hDEADBEEF);
    check("t3_load_data", 64'(bus.reg_wr_data), 64'hDEADBEEF);

    // Saturation of r7, then a coincident set and clear.
    set_reg(7);
    set_reg(7);
    set_reg(7);
    set_reg(7);
    check("t4_sat_stall", 64'(last_stall), 64'd1);
    retire(1, 0, 7, 32'h77, 32'h0);
    set_reg(7);
    check("t4_sat_during_clear", 64'(last_stall), 64'd1);
    retire(1, 0, 7, 32'h78, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    check("t4_set_clear_accept", 64'(last_stall), 64'd0);
    set_reg(7);
    set_reg(7);
    check("t4_resat_stall", 64'(last_stall), 64'd1);

    retire(1, 0, 0, 32'h55, 32'h0);
    check("t5_r0_no_write", 64'(bus.reg_write), 64'd0);
    set_reg(0);
    check("t5_busy0", 64'(bus.busy_flags[0]), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    check("t5_r0_no_stall", 64'(last_stall), 64'd0);

    retire(1, 0, 9, 32'h99, 32'h0);
    idle();
    check("t6_underflow", 64'(bus.sb_underflow), 64'd1);
    idle();
    idle();
    check("t6_underflow_held", 64'(bus.sb_underflow), 64'd1);

    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        // Asynchronous reset between edges with work in flight.
        retire(1, 0, 5, 32'hAA, 32'h0);
        drive(1, 1, 0, 5'd7, 32'h1, 32'h2, 1, 5'd9, 1, 5'd7, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t1_reg_write", 64'(bus.reg_write), 64'd0);
        check("t1_busy", 64'(bus.busy_flags), 64'd0);
        check("t1_retired", 64'(bus.retired_count), 64'd0);
        check("t1_underflow", 64'(bus.sb_underflow), 64'd0);
        check("t1_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        check_outputs("t1_hold");
        reset = 1'b1;
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           pick_reg(), $urandom(), $urandom(),
           1'($urandom_range(0, 9) < 6), pick_reg(),
           1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)), pick_reg());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
